// File: rtl/posit_pio_sequencer_pkg.sv
// Shared types and bit positions for the posit PIO command sequencer.
package posit_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_e;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_TIMEOUT   = 2;
    localparam int STAT_OVERRUN   = 3;
    localparam int STAT_COUNT_LSB = 16;

    localparam int CTRL_START  = 0;
    localparam int CTRL_OP_LSB = 1;
    localparam int CTRL_OP_MSB = 3;

endpackage

// File: rtl/posit_pio_sequencer_toggle_detect.sv
// Turns a software-flipped start bit into a one-cycle start request; the
// primed flag masks the first cycle after reset so a stale 1 never fires.
module toggle_detect (
    input  logic clock,
    input  logic reset,
    input  logic toggle_i,
    output logic start_o
);

    logic ctrl_q;
    logic primed_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            ctrl_q   <= toggle_i;
            primed_q <= 1'b1;
        end
    end

    assign start_o = primed_q && (toggle_i != ctrl_q);

endmodule

// File: rtl/posit_pio_sequencer.sv
// Captures an HPS command, issues it to the posit core with a one-cycle strobe,
// then latches the result or a timeout into the status word.
module posit_pio_sequencer
    import posit_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      io_ctrl,
    input  logic [WIDTH-1:0] io_num1,
    input  logic [WIDTH-1:0] io_num2,
    output logic [WIDTH-1:0] io_result,
    output logic [31:0]      io_status,
    output logic             io_core_valid,
    output logic [2:0]       io_core_op,
    output logic [WIDTH-1:0] io_core_num1,
    output logic [WIDTH-1:0] io_core_num2,
    input  logic [WIDTH-1:0] io_core_result,
    input  logic             io_core_result_valid
);

    // Counter is zero on the first WAIT cycle, so WAIT cycle TIMEOUT sees TIMEOUT-1.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    seq_state_e       state_q, state_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic [15:0]      count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] num1_q, num1_d;
    logic [WIDTH-1:0] num2_q, num2_d;
    logic [2:0]       op_q, op_d;
    logic             core_valid_q, core_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;

    logic             start_req;
    logic             complete;
    logic             abort;
    logic             unused_ctrl;

    assign unused_ctrl = ^io_ctrl[31:CTRL_OP_MSB+1];

    toggle_detect u_toggle_detect (
        .clock    (clock),
        .reset    (reset),
        .toggle_i (io_ctrl[CTRL_START]),
        .start_o  (start_req)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            count_q      <= '0;
            result_q     <= '0;
            num1_q       <= '0;
            num2_q       <= '0;
            op_q         <= '0;
            core_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            count_q      <= count_d;
            result_q     <= result_d;
            num1_q       <= num1_d;
            num2_q       <= num2_d;
            op_q         <= op_d;
            core_valid_q <= core_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
        end
    end

    // Result-valid is tested before the limit so completion wins a tie.
    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        abort    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_req) state_d = ISSUE;
            end
            ISSUE: begin
                if (io_core_result_valid) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (io_core_result_valid) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_d   = wait_cnt_q;
        count_d      = count_q;
        result_d     = result_q;
        num1_d       = num1_q;
        num2_d       = num2_q;
        op_d         = op_q;
        core_valid_d = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        overrun_d    = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (start_req) begin
                    num1_d       = io_num1;
                    num2_d       = io_num2;
                    op_d         = io_ctrl[CTRL_OP_MSB:CTRL_OP_LSB];
                    core_valid_d = 1'b1;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    timeout_d    = 1'b0;
                    overrun_d    = 1'b0;
                end
            end
            ISSUE:   wait_cnt_d = '0;
            WAIT:    wait_cnt_d = wait_cnt_q + 16'd1;
            default: wait_cnt_d = '0;
        endcase

        // Requests arriving while busy, including the finishing cycle, are dropped.
        if (state_q != IDLE && start_req) overrun_d = 1'b1;

        if (complete) begin
            result_d = io_core_result;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            count_d  = count_q + 16'd1;
        end

        if (abort) begin
            timeout_d = 1'b1;
            done_d    = 1'b0;
            busy_d    = 1'b0;
        end
    end

    always_comb begin
        io_status                             = '0;
        io_status[STAT_BUSY]                  = busy_q;
        io_status[STAT_DONE]                  = done_q;
        io_status[STAT_TIMEOUT]               = timeout_q;
        io_status[STAT_OVERRUN]               = overrun_q;
        io_status[STAT_COUNT_LSB +: 16]       = count_q;
    end

    assign io_result     = result_q;
    assign io_core_valid = core_valid_q;
    assign io_core_op    = op_q;
    assign io_core_num1  = num1_q;
    assign io_core_num2  = num2_q;

endmodule
